multicycle_control: RTL and testbench

- Control FSM for the multi-cycle MIPS core. It sequences the shared datapath (one memory, one ALU, IR, PC, register file) across FETCH/DECODE/EXEC/MEM/WB steps.
- Supports the same ISA subset as the single-cycle core: lw, sw, lui, addi, addiu, andi, slti, sltiu, beq, j, jal, and R-type add/addu/sub/subu/and/or/xor/nor/sll/srl/sra/slt/sltu/jr/jalr.
- Memory accesses use a ready handshake with an optional watchdog.

---
 rtl/multicycle_control_pkg.sv | 125 ++++++++++++
 rtl/multicycle_control_if.sv | 41 ++++
 rtl/multicycle_outdec.sv | 113 +++++++++++
 rtl/multicycle_control.sv | 124 ++++++++++++
 tb/tb_multicycle_control.sv | 304 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/multicycle_control_pkg.sv
// Shared MIPS definitions for the multi-cycle control path: opcode/funct constants,
// FSM state encoding, datapath mux encodings and the instruction-class decoder.
package mips_defs;

  // Opcodes (IR[31:26])
  localparam logic [5:0] OpRtype = 6'h00;
  localparam logic [5:0] OpJ     = 6'h02;
  localparam logic [5:0] OpJal   = 6'h03;
  localparam logic [5:0] OpBeq   = 6'h04;
  localparam logic [5:0] OpAddi  = 6'h08;
  localparam logic [5:0] OpAddiu = 6'h09;
  localparam logic [5:0] OpSlti  = 6'h0a;
  localparam logic [5:0] OpSltiu = 6'h0b;
  localparam logic [5:0] OpAndi  = 6'h0c;
  localparam logic [5:0] OpLui   = 6'h0f;
  localparam logic [5:0] OpLw    = 6'h23;
  localparam logic [5:0] OpSw    = 6'h2b;

  // R-type funct codes (IR[5:0])
  localparam logic [5:0] FnSll  = 6'h00;
  localparam logic [5:0] FnSrl  = 6'h02;
  localparam logic [5:0] FnSra  = 6'h03;
  localparam logic [5:0] FnJr   = 6'h08;
  localparam logic [5:0] FnJalr = 6'h09;
  localparam logic [5:0] FnAdd  = 6'h20;
  localparam logic [5:0] FnAddu = 6'h21;
  localparam logic [5:0] FnSub  = 6'h22;
  localparam logic [5:0] FnSubu = 6'h23;
  localparam logic [5:0] FnAnd  = 6'h24;
  localparam logic [5:0] FnOr   = 6'h25;
  localparam logic [5:0] FnXor  = 6'h26;
  localparam logic [5:0] FnNor  = 6'h27;
  localparam logic [5:0] FnSlt  = 6'h2a;
  localparam logic [5:0] FnSltu = 6'h2b;

  // Mux / ALU encodings
  localparam logic [1:0] AluOpAdd    = 2'b00;
  localparam logic [1:0] AluOpSub    = 2'b01;
  localparam logic [1:0] AluOpFunct  = 2'b10;
  localparam logic [1:0] AluOpOpcode = 2'b11;

  localparam logic [1:0] PcSrcAlu    = 2'b00;
  localparam logic [1:0] PcSrcAluOut = 2'b01;
  localparam logic [1:0] PcSrcJump   = 2'b10;
  localparam logic [1:0] PcSrcRs     = 2'b11;

  localparam logic [1:0] RegDstRt = 2'b00;
  localparam logic [1:0] RegDstRd = 2'b01;
  localparam logic [1:0] RegDstRa = 2'b10;

  localparam logic [1:0] MemtoRegAluOut = 2'b00;
  localparam logic [1:0] MemtoRegMdr    = 2'b01;
  localparam logic [1:0] MemtoRegPc     = 2'b10;

  localparam logic [1:0] SrcAPc    = 2'b00;
  localparam logic [1:0] SrcARs    = 2'b01;
  localparam logic [1:0] SrcAShamt = 2'b10;

  localparam logic [1:0] SrcBRt     = 2'b00;
  localparam logic [1:0] SrcBFour   = 2'b01;
  localparam logic [1:0] SrcBImm    = 2'b10;
  localparam logic [1:0] SrcBImmSl2 = 2'b11;

  typedef enum logic [3:0] {
    StFetch    = 4'd0,
    StDecode   = 4'd1,
    StMemAddr  = 4'd2,
    StMemRead  = 4'd3,
    StMemWb    = 4'd4,
    StMemWrite = 4'd5,
    StRExec    = 4'd6,
    StRWb      = 4'd7,
    StIExec    = 4'd8,
    StIWb      = 4'd9,
    StBranch   = 4'd10,
    StJump     = 4'd11,
    StJr       = 4'd12
  } state_e;

  typedef enum logic [2:0] {
    ClsMem, ClsR, ClsJr, ClsBranch, ClsJump, ClsIAlu, ClsIllegal
  } class_e;

  typedef struct packed {
    logic       pc_write;
    logic       pc_write_cond;
    logic [1:0] pc_source;
    logic       iord;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic       reg_write;
    logic [1:0] reg_dst;
    logic [1:0] memto_reg;
    logic [1:0] alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic       ext_op;
    logic       lu_op;
    logic       instr_done;
    logic       illegal;
  } ctrl_t;

  function automatic class_e decode_class(logic [5:0] op, logic [5:0] funct);
    class_e cls;
    cls = ClsIllegal;
    case (op)
      OpRtype: begin
        case (funct)
          FnJr, FnJalr: cls = ClsJr;
          FnSll, FnSrl, FnSra, FnAdd, FnAddu, FnSub, FnSubu,
          FnAnd, FnOr, FnXor, FnNor, FnSlt, FnSltu: cls = ClsR;
          default: cls = ClsIllegal;
        endcase
      end
      OpLw, OpSw:                                     cls = ClsMem;
      OpBeq:                                          cls = ClsBranch;
      OpJ, OpJal:                                     cls = ClsJump;
      OpAddi, OpAddiu, OpSlti, OpSltiu, OpAndi, OpLui: cls = ClsIAlu;
      default:                                        cls = ClsIllegal;
    endcase
    return cls;
  endfunction

endpackage

// File: rtl/multicycle_control_if.sv
// Control <-> datapath bundle for the multi-cycle MIPS core.
// master: the control FSM (reads IR fields, Zero, mem_ready; drives all controls).
// slave:  the datapath/memory side.
interface multicycle_control_if;
  logic [5:0] OpCode;
  logic [5:0] Funct;
  logic       Zero;
  logic       mem_ready;
  logic       PCWrite;
  logic       PCWriteCond;
  logic [1:0] PCSource;
  logic       IorD;
  logic       MemRead;
  logic       MemWrite;
  logic       IRWrite;
  logic       RegWrite;
  logic [1:0] RegDst;
  logic [1:0] MemtoReg;
  logic [1:0] ALUSrcA;
  logic [1:0] ALUSrcB;
  logic [1:0] ALUOp;
  logic       ExtOp;
  logic       LuOp;
  logic       instr_done;
  logic       illegal;
  logic       mem_err;

  modport master (
    input  OpCode, Funct, Zero, mem_ready,
    output PCWrite, PCWriteCond, PCSource, IorD, MemRead, MemWrite, IRWrite, RegWrite,
           RegDst, MemtoReg, ALUSrcA, ALUSrcB, ALUOp, ExtOp, LuOp, instr_done, illegal,
           mem_err
  );

  modport slave (
    output OpCode, Funct, Zero, mem_ready,
    input  PCWrite, PCWriteCond, PCSource, IorD, MemRead, MemWrite, IRWrite, RegWrite,
           RegDst, MemtoReg, ALUSrcA, ALUSrcB, ALUOp, ExtOp, LuOp, instr_done, illegal,
           mem_err
  );
endinterface

// File: rtl/multicycle_outdec.sv
// Output decoder: current FSM state + OpCode/Funct (+ mem_ready for the handshake
// states) -> datapath control word. Purely combinational.
//   state_i     current FSM state
//   op_i        IR[31:26]
//   funct_i     IR[5:0]
//   mem_ready_i memory completes the current access this cycle
//   ctrl_o      control word; fields not set for a state stay 0
module multicycle_outdec
  import mips_defs::*;
(
  input  state_e     state_i,
  input  logic [5:0] op_i,
  input  logic [5:0] funct_i,
  input  logic       mem_ready_i,
  output ctrl_t      ctrl_o
);

  logic is_shift;
  logic is_link_jump;
  logic is_link_jr;

  assign is_shift     = (funct_i == FnSll) || (funct_i == FnSrl) || (funct_i == FnSra);
  assign is_link_jump = (op_i == OpJal);
  assign is_link_jr   = (funct_i == FnJalr);

  always_comb begin
    ctrl_o = '0;
    unique case (state_i)
      StFetch: begin
        ctrl_o.mem_read = 1'b1;
        if (mem_ready_i) begin
          ctrl_o.ir_write  = 1'b1;
          ctrl_o.pc_write  = 1'b1;
          ctrl_o.alu_src_b = SrcBFour;
        end
      end
      StDecode: begin
        // Speculatively compute the branch target into ALUOut.
        ctrl_o.alu_src_b = SrcBImmSl2;
        ctrl_o.illegal   = (decode_class(op_i, funct_i) == ClsIllegal);
      end
      StMemAddr: begin
        ctrl_o.alu_src_a = SrcARs;
        ctrl_o.alu_src_b = SrcBImm;
        ctrl_o.ext_op    = 1'b1;
      end
      StMemRead: begin
        ctrl_o.mem_read = 1'b1;
        ctrl_o.iord     = 1'b1;
      end
      StMemWb: begin
        ctrl_o.reg_write  = 1'b1;
        ctrl_o.memto_reg  = MemtoRegMdr;
        ctrl_o.instr_done = 1'b1;
      end
      StMemWrite: begin
        ctrl_o.mem_write  = 1'b1;
        ctrl_o.iord       = 1'b1;
        ctrl_o.instr_done = mem_ready_i;
      end
      StRExec: begin
        ctrl_o.alu_src_a = is_shift ? SrcAShamt : SrcARs;
        ctrl_o.alu_op    = AluOpFunct;
      end
      StRWb: begin
        ctrl_o.reg_write  = 1'b1;
        ctrl_o.reg_dst    = RegDstRd;
        ctrl_o.instr_done = 1'b1;
      end
      StIExec: begin
        ctrl_o.alu_src_a = SrcARs;
        ctrl_o.alu_src_b = SrcBImm;
        ctrl_o.alu_op    = AluOpOpcode;
        ctrl_o.ext_op    = (op_i != OpAndi);
        ctrl_o.lu_op     = (op_i == OpLui);
      end
      StIWb: begin
        ctrl_o.reg_write  = 1'b1;
        ctrl_o.instr_done = 1'b1;
      end
      StBranch: begin
        ctrl_o.alu_src_a     = SrcARs;
        ctrl_o.alu_op        = AluOpSub;
        ctrl_o.pc_write_cond = 1'b1;
        ctrl_o.pc_source     = PcSrcAluOut;
        ctrl_o.instr_done    = 1'b1;
      end
      StJump: begin
        ctrl_o.pc_write   = 1'b1;
        ctrl_o.pc_source  = PcSrcJump;
        ctrl_o.instr_done = 1'b1;
        // PC already holds PC+4, which is the link value.
        if (is_link_jump) begin
          ctrl_o.reg_write = 1'b1;
          ctrl_o.reg_dst   = RegDstRa;
          ctrl_o.memto_reg = MemtoRegPc;
        end
      end
      StJr: begin
        ctrl_o.pc_write   = 1'b1;
        ctrl_o.pc_source  = PcSrcRs;
        ctrl_o.instr_done = 1'b1;
        if (is_link_jr) begin
          ctrl_o.reg_write = 1'b1;
          ctrl_o.reg_dst   = RegDstRa;
          ctrl_o.memto_reg = MemtoRegPc;
        end
      end
      default: ctrl_o = '0;
    endcase
  end

endmodule

// File: rtl/multicycle_control.sv
// Multi-cycle MIPS control FSM: state register, next-state logic and memory watchdog.
// Output decoding lives in multicycle_outdec.
//   clk    system clock
//   reset  asynchronous active-low reset; forces all outputs to 0 while low
//   bus    control bundle (master side)
// MEM_TIMEOUT = 0 disables the watchdog.
module multicycle_control
  import mips_defs::*;
#(
  parameter int unsigned STATE_W     = 4,
  parameter int unsigned MEM_TIMEOUT = 0
) (
  input  logic                 clk,
  input  logic                 reset,
  multicycle_control_if.master bus
);

  localparam int unsigned CntW = (MEM_TIMEOUT > 0) ? $clog2(MEM_TIMEOUT + 1) : 1;

  logic [STATE_W-1:0] state_q, state_d;
  logic [CntW-1:0]    count_q, count_d;
  state_e             state_cur, state_nxt;
  class_e             cls;
  logic               wait_st;
  logic               abort;
  ctrl_t              ctrl_dec, ctrl;

  // Zero gates PCWriteCond inside the datapath, not here.
  logic unused_zero;
  assign unused_zero = bus.Zero;

  assign state_cur = state_e'(state_q);

  always_comb begin
    cls     = decode_class(bus.OpCode, bus.Funct);
    wait_st = (state_cur == StFetch) || (state_cur == StMemRead) || (state_cur == StMemWrite);
    // mem_ready wins on the timeout cycle.
    abort   = (MEM_TIMEOUT != 0) && wait_st && !bus.mem_ready &&
              (count_q == CntW'(MEM_TIMEOUT));

    state_nxt = state_cur;
    unique case (state_cur)
      StFetch:    if (bus.mem_ready) state_nxt = StDecode;
      StDecode: begin
        unique case (cls)
          ClsMem:    state_nxt = StMemAddr;
          ClsR:      state_nxt = StRExec;
          ClsJr:     state_nxt = StJr;
          ClsBranch: state_nxt = StBranch;
          ClsJump:   state_nxt = StJump;
          ClsIAlu:   state_nxt = StIExec;
          default:   state_nxt = StFetch;
        endcase
      end
      StMemAddr:  state_nxt = (bus.OpCode == OpLw) ? StMemRead : StMemWrite;
      StMemRead:  if (bus.mem_ready) state_nxt = StMemWb;
      StMemWrite: if (bus.mem_ready) state_nxt = StFetch;
      StRExec:    state_nxt = StRWb;
      StIExec:    state_nxt = StIWb;
      default:    state_nxt = StFetch;
    endcase
    if (abort) state_nxt = StFetch;
    state_d = STATE_W'(state_nxt);

    // Abort also clears: a FETCH timeout does not change state.
    if (abort || (state_d != state_q)) begin
      count_d = '0;
    end else if ((MEM_TIMEOUT != 0) && wait_st && !bus.mem_ready) begin
      count_d = count_q + 1'b1;
    end else begin
      count_d = count_q;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= STATE_W'(StFetch);
      count_q <= '0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
    end
  end

  multicycle_outdec u_outdec (
    .state_i     (state_cur),
    .op_i        (bus.OpCode),
    .funct_i     (bus.Funct),
    .mem_ready_i (bus.mem_ready),
    .ctrl_o      (ctrl_dec)
  );

  always_comb begin
    ctrl = ctrl_dec;
    if (abort) begin
      ctrl.ir_write   = 1'b0;
      ctrl.pc_write   = 1'b0;
      ctrl.reg_write  = 1'b0;
      ctrl.mem_write  = 1'b0;
      ctrl.instr_done = 1'b0;
    end
    if (!reset) ctrl = '0;
  end

  assign bus.PCWrite     = ctrl.pc_write;
  assign bus.PCWriteCond = ctrl.pc_write_cond;
  assign bus.PCSource    = ctrl.pc_source;
  assign bus.IorD        = ctrl.iord;
  assign bus.MemRead     = ctrl.mem_read;
  assign bus.MemWrite    = ctrl.mem_write;
  assign bus.IRWrite     = ctrl.ir_write;
  assign bus.RegWrite    = ctrl.reg_write;
  assign bus.RegDst      = ctrl.reg_dst;
  assign bus.MemtoReg    = ctrl.memto_reg;
  assign bus.ALUSrcA     = ctrl.alu_src_a;
  assign bus.ALUSrcB     = ctrl.alu_src_b;
  assign bus.ALUOp       = ctrl.alu_op;
  assign bus.ExtOp       = ctrl.ext_op;
  assign bus.LuOp        = ctrl.lu_op;
  assign bus.instr_done  = ctrl.instr_done;
  assign bus.illegal     = ctrl.illegal;
  assign bus.mem_err     = reset && abort;

endmodule

// File: tb/tb_multicycle_control.sv
module tb_multicycle_control;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  multicycle_control_if nf_if ();
  multicycle_control_if wd_if ();

  assign wd_if.OpCode    = nf_if.OpCode;
  assign wd_if.Funct     = nf_if.Funct;
  assign wd_if.Zero      = nf_if.Zero;
  assign wd_if.mem_ready = nf_if.mem_ready;

  multicycle_control #(.STATE_W(4), .MEM_TIMEOUT(0)) u_nf (.clk(clk), .reset(reset), .bus(nf_if));
  multicycle_control #(.STATE_W(4), .MEM_TIMEOUT(3)) u_wd (.clk(clk), .reset(reset), .bus(wd_if));

  typedef struct packed {
    logic       pcw, pcwc;
    logic [1:0] pcsrc;
    logic       iord, mrd, mwr, irw, rw;
    logic [1:0] rdst, m2r, asa, asb, aop;
    logic       ext, lu, done, ill, merr;
  } obs_t;

  typedef struct {
    logic rdy;
    obs_t exp;
  } step_t;

  // fin = {PCWrite, PCWriteCond, PCSource, RegWrite, RegDst, MemtoReg} on the retire cycle
  typedef struct {
    logic [5:0] op;
    logic [5:0] fn;
    logic       zero;
    int         cycles;
    logic [8:0] fin;
  } vec_t;

  int n_tests, n_fail;
  step_t trace_q[$];

  function automatic obs_t get_obs(input bit wd);
    if (wd)
      return {wd_if.PCWrite, wd_if.PCWriteCond, wd_if.PCSource, wd_if.IorD, wd_if.MemRead,
              wd_if.MemWrite, wd_if.IRWrite, wd_if.RegWrite, wd_if.RegDst, wd_if.MemtoReg,
              wd_if.ALUSrcA, wd_if.ALUSrcB, wd_if.ALUOp, wd_if.ExtOp, wd_if.LuOp,
              wd_if.instr_done, wd_if.illegal, wd_if.mem_err};
    return {nf_if.PCWrite, nf_if.PCWriteCond, nf_if.PCSource, nf_if.IorD, nf_if.MemRead,
            nf_if.MemWrite, nf_if.IRWrite, nf_if.RegWrite, nf_if.RegDst, nf_if.MemtoReg,
            nf_if.ALUSrcA, nf_if.ALUSrcB, nf_if.ALUOp, nf_if.ExtOp, nf_if.LuOp,
            nf_if.instr_done, nf_if.illegal, nf_if.mem_err};
  endfunction

  task automatic chk(input string nm, input obs_t got, input obs_t exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b required %b", nm, got, exp);
    end
  endtask

  task automatic chk_int(input string nm, input int got, input int exp);
    n_tests++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d required %0d", nm, got, exp);
    end
  endtask

  function automatic bit tb_legal(input logic [5:0] op, input logic [5:0] fn);
    if (op == 6'h00)
      return fn inside {6'h00, 6'h02, 6'h03, 6'h08, 6'h09, 6'h20, 6'h21, 6'h22, 6'h23,
                        6'h24, 6'h25, 6'h26, 6'h27, 6'h2a, 6'h2b};
    return op inside {6'h02, 6'h03, 6'h04, 6'h08, 6'h09, 6'h0a, 6'h0b, 6'h0c, 6'h0f,
                      6'h23, 6'h2b};
  endfunction

  function automatic void push(input logic rdy, input obs_t o);
    step_t s;
    s.rdy = rdy;
    s.exp = o;
    trace_q.push_back(s);
  endfunction

  // Expected per-cycle trace of one instruction, from the instruction-level rules.
  function automatic void build(input logic [5:0] op, input logic [5:0] fn,
                                input int fw, input int mw);
    obs_t o;
    bit   link;
    for (int i = 0; i < fw; i++) begin
      o = '0; o.mrd = 1'b1; push(1'b0, o);
    end
    o = '0; o.mrd = 1'b1; o.irw = 1'b1; o.pcw = 1'b1; o.asb = 2'b01; push(1'b1, o);
    o = '0; o.asb = 2'b11; o.ill = !tb_legal(op, fn); push(1'($urandom_range(0, 1)), o);
    if (!tb_legal(op, fn)) return;
    if (op == 6'h23 || op == 6'h2b) begin
      o = '0; o.asa = 2'b01; o.asb = 2'b10; o.ext = 1'b1; push(1'($urandom_range(0, 1)), o);
      for (int i = 0; i <= mw; i++) begin
        o = '0; o.iord = 1'b1;
        if (op == 6'h23) o.mrd = 1'b1;
        else begin
          o.mwr = 1'b1; o.done = (i == mw);
        end
        push(i == mw, o);
      end
      if (op == 6'h23) begin
        o = '0; o.rw = 1'b1; o.m2r = 2'b01; o.done = 1'b1; push(1'($urandom_range(0, 1)), o);
      end
    end else if (op == 6'h00 && (fn == 6'h08 || fn == 6'h09)) begin
      link = (fn == 6'h09);
      o = '0; o.pcw = 1'b1; o.pcsrc = 2'b11; o.done = 1'b1;
      o.rw = link; o.rdst = link ? 2'b10 : 2'b00; o.m2r = link ? 2'b10 : 2'b00;
      push(1'($urandom_range(0, 1)), o);
    end else if (op == 6'h00) begin
      o = '0; o.aop = 2'b10; o.asa = (fn inside {6'h00, 6'h02, 6'h03}) ? 2'b10 : 2'b01;
      push(1'($urandom_range(0, 1)), o);
      o = '0; o.rw = 1'b1; o.rdst = 2'b01; o.done = 1'b1; push(1'($urandom_range(0, 1)), o);
    end else if (op == 6'h04) begin
      o = '0; o.asa = 2'b01; o.aop = 2'b01; o.pcwc = 1'b1; o.pcsrc = 2'b01; o.done = 1'b1;
      push(1'($urandom_range(0, 1)), o);
    end else if (op == 6'h02 || op == 6'h03) begin
      link = (op == 6'h03);
      o = '0; o.pcw = 1'b1; o.pcsrc = 2'b10; o.done = 1'b1;
      o.rw = link; o.rdst = link ? 2'b10 : 2'b00; o.m2r = link ? 2'b10 : 2'b00;
      push(1'($urandom_range(0, 1)), o);
    end else begin
      o = '0; o.asa = 2'b01; o.asb = 2'b10; o.aop = 2'b11;
      o.ext = (op != 6'h0c); o.lu = (op == 6'h0f);
      push(1'($urandom_range(0, 1)), o);
      o = '0; o.rw = 1'b1; o.done = 1'b1; push(1'($urandom_range(0, 1)), o);
    end
  endfunction

  // Called at posedge+1 with both DUTs in FETCH; returns there.
  task automatic do_instr(input logic [5:0] op, input logic [5:0] fn, input int fw,
                          input int mw, input bit chk_wd);
    step_t s;
    int    idx;
    nf_if.OpCode = op;
    nf_if.Funct  = fn;
    nf_if.Zero   = 1'($urandom_range(0, 1));
    build(op, fn, fw, mw);
    idx = 0;
    while (trace_q.size() > 0) begin
      s = trace_q.pop_front();
      nf_if.mem_ready = s.rdy;
      @(negedge clk);
      chk($sformatf("nf op%02h fn%02h c%0d", op, fn, idx), get_obs(1'b0), s.exp);
      if (chk_wd) chk($sformatf("wd op%02h fn%02h c%0d", op, fn, idx), get_obs(1'b1), s.exp);
      @(posedge clk); #1;
      idx++;
    end
  endtask

  vec_t       tbl[16];
  logic [5:0] op_pool[14];
  logic [5:0] fn_pool[17];

  initial begin
    obs_t       o;
    int         cyc;
    bit         got_done;
    logic [8:0] fin;
    logic [5:0] op, fn;

    tbl = '{
      '{6'h23, 6'h00, 1'b0, 5, 9'b0_0_00_1_00_01},  // lw
      '{6'h2b, 6'h00, 1'b0, 4, 9'b0_0_00_0_00_00},  // sw
      '{6'h00, 6'h20, 1'b0, 4, 9'b0_0_00_1_01_00},  // add
      '{6'h00, 6'h00, 1'b0, 4, 9'b0_0_00_1_01_00},  // sll
      '{6'h00, 6'h03, 1'b0, 4, 9'b0_0_00_1_01_00},  // sra
      '{6'h00, 6'h2b, 1'b0, 4, 9'b0_0_00_1_01_00},  // sltu
      '{6'h08, 6'h00, 1'b0, 4, 9'b0_0_00_1_00_00},  // addi
      '{6'h0c, 6'h00, 1'b0, 4, 9'b0_0_00_1_00_00},  // andi
      '{6'h0f, 6'h00, 1'b0, 4, 9'b0_0_00_1_00_00},  // lui
      '{6'h0b, 6'h00, 1'b0, 4, 9'b0_0_00_1_00_00},  // sltiu
      '{6'h04, 6'h00, 1'b1, 3, 9'b0_1_01_0_00_00},  // beq, Zero=1
      '{6'h04, 6'h00, 1'b0, 3, 9'b0_1_01_0_00_00},  // beq, Zero=0
      '{6'h02, 6'h00, 1'b0, 3, 9'b1_0_10_0_00_00},  // j
      '{6'h03, 6'h00, 1'b0, 3, 9'b1_0_10_1_10_10},  // jal
      '{6'h00, 6'h08, 1'b0, 3, 9'b1_0_11_0_00_00},  // jr
      '{6'h00, 6'h09, 1'b0, 3, 9'b1_0_11_1_10_10}   // jalr
    };
    op_pool = '{6'h02, 6'h03, 6'h04, 6'h08, 6'h09, 6'h0a, 6'h0b, 6'h0c, 6'h0f,
                6'h23, 6'h2b, 6'h3f, 6'h05, 6'h20};
    fn_pool = '{6'h00, 6'h02, 6'h03, 6'h08, 6'h09, 6'h20, 6'h21, 6'h22, 6'h23,
                6'h24, 6'h25, 6'h26, 6'h27, 6'h2a, 6'h2b, 6'h18, 6'h01};

    n_tests = 0;
    n_fail  = 0;
    reset   = 1'b0;
    nf_if.OpCode    = 6'h23;
    nf_if.Funct     = 6'h00;
    nf_if.Zero      = 1'b0;
    nf_if.mem_ready = 1'b1;

    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("reset nf", get_obs(1'b0), '0);
      chk("reset wd", get_obs(1'b1), '0);
    end
    @(posedge clk); #1;
    reset = 1'b1;

    // Directed table: cycle count and retire-cycle writeback/PC controls.
    for (int i = 0; i < 16; i++) begin
      nf_if.OpCode    = tbl[i].op;
      nf_if.Funct     = tbl[i].fn;
      nf_if.Zero      = tbl[i].zero;
      nf_if.mem_ready = 1'b1;
      cyc = 0; got_done = 1'b0; fin = '0;
      for (int c = 0; c < 20 && !got_done; c++) begin
        @(negedge clk);
        cyc++;
        o = get_obs(1'b0);
        if (o.done) begin
          got_done = 1'b1;
          fin = {o.pcw, o.pcwc, o.pcsrc, o.rw, o.rdst, o.m2r};
        end
        @(posedge clk); #1;
      end
      if (!got_done) begin
        n_tests++; n_fail++;
        $display("FAIL tbl%0d op%02h: no instr_done within 20 cycles", i, tbl[i].op);
      end else begin
        chk_int($sformatf("tbl%0d op%02h fn%02h cycles", i, tbl[i].op, tbl[i].fn), cyc,
                tbl[i].cycles);
        chk_int($sformatf("tbl%0d op%02h fn%02h final", i, tbl[i].op, tbl[i].fn), fin,
                tbl[i].fin);
      end
    end

    // Random instructions with short memory waits (below the watchdog limit).
    for (int k = 0; k < 150; k++) begin
      if ($urandom_range(0, 3) == 0) begin
        op = 6'h00;
        fn = fn_pool[$urandom_range(0, 16)];
      end else begin
        op = op_pool[$urandom_range(0, 13)];
        fn = 6'($urandom_range(0, 63));
      end
      do_instr(op, fn, $urandom_range(0, 2), $urandom_range(0, 2), 1'b1);
    end

    // Watchdog: mem_ready stuck low in FETCH.
    nf_if.OpCode    = 6'h3f;
    nf_if.mem_ready = 1'b0;
    for (int i = 0; i < 8; i++) begin
      nf_if.mem_ready = (i == 7);
      @(negedge clk);
      o = '0; o.mrd = 1'b1;
      if (i == 7) begin
        o.irw = 1'b1; o.pcw = 1'b1; o.asb = 2'b01;
      end
      chk($sformatf("nf wait c%0d", i), get_obs(1'b0), o);
      o.merr = (i == 3);
      chk($sformatf("wd timeout c%0d", i), get_obs(1'b1), o);
      @(posedge clk); #1;
    end
    // Decode of an unsupported opcode, then back to FETCH.
    nf_if.mem_ready = 1'b0;
    @(negedge clk);
    o = '0; o.asb = 2'b11; o.ill = 1'b1;
    chk("illegal decode nf", get_obs(1'b0), o);
    chk("illegal decode wd", get_obs(1'b1), o);
    @(posedge clk); #1;
    @(negedge clk);
    o = '0; o.mrd = 1'b1;
    chk("after illegal nf", get_obs(1'b0), o);
    chk("after illegal wd", get_obs(1'b1), o);
    @(posedge clk); #1;

    // Long store wait on the watchdog-free DUT; then sll.
    do_instr(6'h2b, 6'h00, 0, 4, 1'b0);
    do_instr(6'h00, 6'h00, 0, 0, 1'b0);

    // Reset asserted during MEM_READ.
    nf_if.OpCode    = 6'h23;
    nf_if.mem_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
    end
    nf_if.mem_ready = 1'b0;
    @(negedge clk);
    o = '0; o.mrd = 1'b1; o.iord = 1'b1;
    chk("in mem_read", get_obs(1'b0), o);
    #2;
    reset = 1'b0;
    #1;
    chk("async reset nf", get_obs(1'b0), '0);
    chk("async reset wd", get_obs(1'b1), '0);
    @(posedge clk); #1;
    reset = 1'b1;
    @(negedge clk);
    o = '0; o.mrd = 1'b1;
    chk("post reset nf", get_obs(1'b0), o);
    chk("post reset wd", get_obs(1'b1), o);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
